// File: rtl/mult_div_pkg.sv
// Shared opcode, state encodings and default operand width for the
// sequential multiplier/divider.
package mult_div_pkg;

    localparam int W_DEF = 16;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/mult_div_datapath.sv
// Operand/accumulator/remainder/quotient registers with one shift-add or
// restoring-divide iteration per step.
module mult_div_datapath
    import mult_div_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = $clog2(W)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             step,
    input  logic [CNT_W-1:0] cnt,
    input  logic             op_in,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [2*W-1:0]   dp_result,
    output logic             op_div,
    output logic             b_zero
);

    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [W-1:0]   divisor;
    logic [2*W-1:0] acc;
    logic [W-1:0]   rem;
    logic [W-1:0]   quo;
    logic           op_reg;

    logic [2*W-1:0] acc_next;
    logic [W:0]     r_sh;
    logic [W:0]     r_sub;
    logic           r_ge;

    always_comb begin
        acc_next = acc;
        if (mplier[0])
            acc_next = acc + ({{W{1'b0}}, mcand} << cnt);
    end

    // Partial remainder needs W+1 bits only between shift and compare;
    // after a restoring subtract it always fits back into W bits.
    assign r_sh  = {rem, quo[W-1]};
    assign r_ge  = (r_sh >= {1'b0, divisor});
    assign r_sub = r_sh - {1'b0, divisor};

    always_ff @(posedge CLK) begin
        if (RST) begin
            mcand   <= '0;
            mplier  <= '0;
            divisor <= '0;
            acc     <= '0;
            rem     <= '0;
            quo     <= '0;
            op_reg  <= OP_MUL;
        end else if (load) begin
            mcand   <= a;
            mplier  <= b;
            divisor <= b;
            acc     <= '0;
            rem     <= '0;
            quo     <= a;
            op_reg  <= op_in;
        end else if (step) begin
            acc    <= acc_next;
            mplier <= mplier >> 1;
            if (r_ge) begin
                rem <= r_sub[W-1:0];
                quo <= {quo[W-2:0], 1'b1};
            end else begin
                rem <= r_sh[W-1:0];
                quo <= {quo[W-2:0], 1'b0};
            end
        end
    end

    assign dp_result = (op_reg == OP_DIV) ? {rem, quo} : acc;
    assign op_div    = (op_reg == OP_DIV);
    assign b_zero    = (divisor == '0);

endmodule

// File: rtl/seq_mult_div.sv
// Start/busy/done sequencer around the multiply/divide datapath; result is
// only updated in FIN so a downstream display never sees partial values.
module seq_mult_div
    import mult_div_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           start,
    input  logic           op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] result,
    output logic           busy,
    output logic           done,
    output logic           valid,
    output logic           dz
);

    localparam int CNT_W = $clog2(W);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             load;
    logic             step;
    logic [2*W-1:0]   dp_result;
    logic             op_div;
    logic             b_zero;

    assign load = (state == S_IDLE) && start;
    assign step = (state == S_CALC);

    mult_div_datapath #(.W(W), .CNT_W(CNT_W)) u_datapath (
        .CLK       (CLK),
        .RST       (RST),
        .load      (load),
        .step      (step),
        .cnt       (cnt),
        .op_in     (op),
        .a         (a),
        .b         (b),
        .dp_result (dp_result),
        .op_div    (op_div),
        .b_zero    (b_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= S_IDLE;
            cnt    <= '0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            valid  <= 1'b0;
            dz     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CALC;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(W - 1))
                        state <= S_FIN;
                end
                S_FIN: begin
                    result <= dp_result;
                    done   <= 1'b1;
                    valid  <= 1'b1;
                    dz     <= op_div && b_zero;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
